// File: rtl/bcd_key_entry_to_bin_pkg.sv
// Shared types and constants for the decimal key-entry front end.
// Holds the FSM state encoding, the largest legal digit and the BCD width helper.
package bcd_key_entry_to_bin_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic int bcd_width(input int n_digits);
    return 4 * n_digits;
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// One BCD digit correction step of reverse double-dabble.
// After the right shift, a nibble of 8 or more has 3 subtracted.
module bcd_nibble_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd_key_entry_to_bin.sv
// Decimal key-entry buffer with a sequential BCD-to-binary converter.
// Digits are shifted in newest-last; enter runs one reverse double-dabble step per clock.
module bcd_key_entry_to_bin
  import bcd_key_entry_to_bin_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [3:0]              i_digit,
  input  logic                    i_digit_vld,
  input  logic                    i_enter,
  input  logic                    i_clear,
  output logic [4*N_DIGITS-1:0]   o_bcd,
  output logic [2:0]              o_digit_cnt,
  output logic                    o_busy,
  output logic [BIN_W-1:0]        o_bin,
  output logic                    o_bin_vld,
  output logic                    o_err
);

  localparam int BCD_W  = bcd_width(N_DIGITS);
  localparam int SR_W   = 2 * BCD_W;
  localparam int ITER_W = (BCD_W > 1) ? $clog2(BCD_W) : 1;

  generate
    if ((longint'(1) << BIN_W) <= longint'(10 ** N_DIGITS - 1)) begin : g_bad_width
      $error("BIN_W too narrow for the largest N_DIGITS decimal value");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BCD_W-1:0]    r_bcd;
  logic [2:0]          r_cnt;
  logic                r_committed;
  logic                r_err;
  logic [SR_W-1:0]     r_sr;
  logic [ITER_W-1:0]   r_iter;
  logic [BIN_W-1:0]    r_bin;
  logic                r_bin_vld;
  logic [SR_W-1:0]     w_shift;
  logic [SR_W-1:0]     w_sr_next;
  logic                w_last;

  // Upper half holds BCD digits being drained; lower half collects the binary result.
  assign w_shift = r_sr >> 1;
  assign w_sr_next[BCD_W-1:0] = w_shift[BCD_W-1:0];

  generate
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (
        .i_nib (w_shift[BCD_W + 4*g +: 4]),
        .o_nib (w_sr_next[BCD_W + 4*g +: 4])
      );
    end
  endgenerate

  assign w_last = (r_iter == ITER_W'(BCD_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!i_clear && i_enter) w_state_nxt = S_CONV;
      S_CONV: if (i_clear || w_last)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_committed <= 1'b0;
      r_err       <= 1'b0;
      r_sr        <= '0;
      r_iter      <= '0;
      r_bin       <= '0;
      r_bin_vld   <= 1'b0;
    end else begin
      r_bin_vld <= 1'b0;
      if (i_clear) begin
        r_bcd       <= '0;
        r_cnt       <= '0;
        r_committed <= 1'b0;
        r_err       <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (i_enter) begin
          r_sr   <= {r_bcd, {BCD_W{1'b0}}};
          r_iter <= '0;
        end else if (i_digit_vld) begin
          if (r_committed) begin
            // A digit after a completed conversion starts a fresh number.
            r_committed <= 1'b0;
            if (i_digit > DIGIT_MAX) begin
              r_bcd <= '0;
              r_cnt <= '0;
              r_err <= 1'b1;
            end else begin
              r_bcd <= {{(BCD_W-4){1'b0}}, i_digit};
              r_cnt <= 3'd1;
            end
          end else if (i_digit > DIGIT_MAX || r_cnt == 3'(N_DIGITS)) begin
            r_err <= 1'b1;
          end else begin
            r_bcd <= {r_bcd[BCD_W-5:0], i_digit};
            r_cnt <= r_cnt + 3'd1;
          end
        end
      end else begin
        r_sr   <= w_sr_next;
        r_iter <= r_iter + ITER_W'(1);
        if (w_last) begin
          r_bin       <= w_sr_next[BIN_W-1:0];
          r_bin_vld   <= 1'b1;
          r_committed <= 1'b1;
        end
      end
    end
  end

  assign o_bcd       = r_bcd;
  assign o_digit_cnt = r_cnt;
  assign o_busy      = (r_state == S_CONV);
  assign o_bin       = r_bin;
  assign o_bin_vld   = r_bin_vld;
  assign o_err       = r_err;

endmodule

// File: tb/tb_bcd_key_entry_to_bin.sv
// Directed bench for the key-entry BCD-to-binary block.
// Drives inputs 1 ns after the rising edge and samples there as well.
module tb_bcd_key_entry_to_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_digit;
  logic        i_digit_vld;
  logic        i_enter;
  logic        i_clear;
  logic [15:0] o_bcd;
  logic [2:0]  o_digit_cnt;
  logic        o_busy;
  logic [13:0] o_bin;
  logic        o_bin_vld;
  logic        o_err;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  bcd_key_entry_to_bin #(.N_DIGITS(4), .BIN_W(14)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_digit     (i_digit),
    .i_digit_vld (i_digit_vld),
    .i_enter     (i_enter),
    .i_clear     (i_clear),
    .o_bcd       (o_bcd),
    .o_digit_cnt (o_digit_cnt),
    .o_busy      (o_busy),
    .o_bin       (o_bin),
    .o_bin_vld   (o_bin_vld),
    .o_err       (o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    i_digit     = d;
    i_digit_vld = 1'b1;
    step();
    i_digit_vld = 1'b0;
  endtask

  task automatic clr();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
  endtask

  // Enter at edge E0, expect busy through 15 more edges and the result pulse at edge 16.
  task automatic enter_conv(input string tag, input logic [13:0] exp, input logic with_digit);
    int busy_cycles;
    i_enter = 1'b1;
    if (with_digit) begin
      i_digit     = 4'd5;
      i_digit_vld = 1'b1;
    end
    step();
    i_enter     = 1'b0;
    i_digit_vld = 1'b0;
    check({tag, "_busy_e0"}, 32'(o_busy), 32'd1);
    busy_cycles = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (o_busy === 1'b1 && o_bin_vld === 1'b0) busy_cycles++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd15);
    step();
    check({tag, "_vld"},  32'(o_bin_vld), 32'd1);
    check({tag, "_idle"}, 32'(o_busy),    32'd0);
    check({tag, "_bin"},  32'(o_bin),     32'(exp));
    step();
    check({tag, "_vld_drop"}, 32'(o_bin_vld), 32'd0);
  endtask

  initial begin
    int vld_seen;
    rst_n       = 1'b0;
    i_digit     = 4'd0;
    i_digit_vld = 1'b0;
    i_enter     = 1'b0;
    i_clear     = 1'b0;
    #25;
    check("rst_bcd",  32'(o_bcd),       32'h0);
    check("rst_cnt",  32'(o_digit_cnt), 32'd0);
    check("rst_busy", 32'(o_busy),      32'd0);
    check("rst_bin",  32'(o_bin),       32'd0);
    check("rst_vld",  32'(o_bin_vld),   32'd0);
    check("rst_err",  32'(o_err),       32'd0);
    rst_n = 1'b1;
    step();

    // 1234
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check("t1_bcd", 32'(o_bcd),       32'h1234);
    check("t1_cnt", 32'(o_digit_cnt), 32'd4);
    enter_conv("t1", 14'h04D2, 1'b0);
    check("t1_err",      32'(o_err), 32'd0);
    check("t1_bcd_kept", 32'(o_bcd), 32'h1234);

    // 9999 after a committed restart, then another restart with 7
    key(4'd9);
    check("t2_restart_bcd", 32'(o_bcd), 32'h0009);
    key(4'd9); key(4'd9); key(4'd9);
    check("t2_bcd", 32'(o_bcd), 32'h9999);
    enter_conv("t2", 14'h270F, 1'b0);
    key(4'd7);
    check("t2_new_bcd", 32'(o_bcd),       32'h0007);
    check("t2_new_cnt", 32'(o_digit_cnt), 32'd1);

    // Empty buffer converts to 0; invalid digit on restart clears buffer and latches error
    clr();
    check("t3_clr_cnt", 32'(o_digit_cnt), 32'd0);
    enter_conv("t3", 14'd0, 1'b0);
    key(4'hA);
    check("t3_bad_err", 32'(o_err),       32'd1);
    check("t3_bad_bcd", 32'(o_bcd),       32'h0);
    check("t3_bad_cnt", 32'(o_digit_cnt), 32'd0);
    key(4'd3);
    check("t3_sticky_err", 32'(o_err), 32'd1);
    check("t3_after_bcd",  32'(o_bcd), 32'h0003);
    clr();
    check("t3_clr_err", 32'(o_err), 32'd0);
    check("t3_clr_bcd", 32'(o_bcd), 32'h0);

    // Fifth digit overflows
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check("t4_bcd", 32'(o_bcd),       32'h1234);
    check("t4_cnt", 32'(o_digit_cnt), 32'd4);
    check("t4_err", 32'(o_err),       32'd1);
    enter_conv("t4", 14'h04D2, 1'b0);

    // Abort at iteration 8; strobes inside CONV are ignored
    clr();
    key(4'd5); key(4'd6);
    i_enter = 1'b1;
    step();
    i_enter = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin
        i_digit     = 4'hB;
        i_digit_vld = 1'b1;
        i_enter     = 1'b1;
      end
      step();
      i_digit_vld = 1'b0;
      i_enter     = 1'b0;
    end
    check("t5_conv_err",  32'(o_err),  32'd0);
    check("t5_conv_bcd",  32'(o_bcd),  32'h0056);
    check("t5_conv_busy", 32'(o_busy), 32'd1);
    clr();
    check("t5_abort_busy", 32'(o_busy),      32'd0);
    check("t5_abort_vld",  32'(o_bin_vld),   32'd0);
    check("t5_abort_bin",  32'(o_bin),       32'h04D2);
    check("t5_abort_bcd",  32'(o_bcd),       32'h0);
    check("t5_abort_cnt",  32'(o_digit_cnt), 32'd0);
    vld_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_bin_vld !== 1'b0 || o_busy !== 1'b0) vld_seen++;
    end
    check("t5_no_late_vld", 32'(vld_seen), 32'd0);

    // Same-cycle enter and digit: digit dropped
    key(4'd1); key(4'd2);
    enter_conv("t6", 14'd12, 1'b1);
    check("t6_bcd", 32'(o_bcd),       32'h0012);
    check("t6_cnt", 32'(o_digit_cnt), 32'd2);
    check("t6_err", 32'(o_err),       32'd0);

    // Asynchronous reset mid-conversion
    i_enter = 1'b1;
    step();
    i_enter = 1'b0;
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", 32'(o_busy),      32'd0);
    check("t7_rst_bin",  32'(o_bin),       32'd0);
    check("t7_rst_bcd",  32'(o_bcd),       32'h0);
    check("t7_rst_cnt",  32'(o_digit_cnt), 32'd0);
    check("t7_rst_vld",  32'(o_bin_vld),   32'd0);
    #5;
    rst_n = 1'b1;
    repeat (20) step();
    check("t7_post_busy", 32'(o_busy),    32'd0);
    check("t7_post_vld",  32'(o_bin_vld), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_key_entry_to_bin.md
Name: bcd_key_entry_to_bin

Overview:
- Decimal key-entry front end: the input-side counterpart of the binary-to-BCD display path.
- Collects up to N_DIGITS decimal digits from debounced key events into a BCD buffer; the buffer can be echoed on the scanned 7-segment display.
- On an enter command, converts the buffer to binary using sequential reverse double-dabble (shift-right, subtract-3), one bit per clock.
- The binary result feeds filter sample/coefficient loading in the experiment tops.

Parameters:
- N_DIGITS, 4, number of BCD digits held; conversion takes 4*N_DIGITS iterations.
- BIN_W, 14, output binary width; must satisfy 2^BIN_W > 10^N_DIGITS - 1 (elaboration error otherwise).

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
- i_digit  in  4  digit value of the current key event.
- i_digit_vld  in  1  one-cycle strobe: i_digit is valid.
- i_enter  in  1  one-cycle strobe: convert the buffer.
- i_clear  in  1  one-cycle strobe: clear the buffer and abort any conversion.
- o_bcd  out  4*N_DIGITS  entry buffer; newest digit in [3:0].
- o_digit_cnt  out  3  digits held, 0..N_DIGITS.
- o_busy  out  1  conversion in progress.
- o_bin  out  BIN_W  last conversion result; held until the next completion.
- o_bin_vld  out  1  one-cycle pulse when o_bin updates.
- o_err  out  1  sticky entry error; cleared only by i_clear or reset.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; committed flag 0; shift registers 0.
- FSM states: IDLE and CONV.
- Strobe priority in IDLE, same cycle: i_clear > i_enter > i_digit_vld. A lower-priority strobe is dropped without error.
- i_clear, any state:
  - next edge: o_bcd=0, o_digit_cnt=0, o_err=0, committed=0, state IDLE, o_busy=0.
  - o_bin is unchanged; no o_bin_vld.
- Digit entry (IDLE, i_digit_vld):
  - If committed=1: buffer restarts. o_bcd={0..,i_digit}, cnt=1, committed=0.
  - Else if i_digit>9: digit ignored; o_err=1.
  - Else if cnt==N_DIGITS: digit ignored; o_err=1; buffer unchanged.
  - Else: o_bcd={o_bcd[4*N_DIGITS-5:0], i_digit}; cnt+1.
  - The committed-restart path also applies the >9 check; in that case the buffer is cleared and o_err=1.
- Enter (IDLE, i_enter):
  - Edge E0: load shift register SR = {o_bcd, (4*N_DIGITS) zero bits}; iteration counter=0; state CONV; o_busy=1.
  - An empty buffer (cnt=0) still converts, giving result 0.
- CONV, each edge = one iteration:
  - SR shifts right 1 bit (logical).
  - Then each BCD nibble of the upper half with value >=8 has 3 subtracted.
  - Iteration counter increments.
- Completion:
  - On edge E0+4*N_DIGITS (edge 16 at default), after that edge's iteration: o_bin <= lower half of SR truncated to BIN_W; o_bin_vld=1 for exactly one cycle; o_busy=0; committed=1; state IDLE.
  - Latency enter->vld: 4*N_DIGITS cycles.
  - o_bcd is not modified by conversion, so the display keeps the entered number.
- During CONV: i_digit_vld and i_enter are ignored and do not set o_err. i_clear aborts as above.
- Back-to-back: an enter arriving in the same cycle o_bin_vld is high is accepted (state is already IDLE).
- Width: the lower half shifted out is 4*N_DIGITS bits; the upper bits beyond BIN_W are guaranteed 0 by the parameter rule.

Decomposition:
- Shared package: FSM state enum (IDLE, CONV); constant DIGIT_MAX=9; localparam helper for BCD width (4*N_DIGITS).
- One natural sub-module: bcd_nibble_adj, a combinational function "if >=8 subtract 3" replicated N_DIGITS times via generate.
- Entry buffer and FSM stay in the top.

Test Plan:
- Digits 1,2,3,4 then enter -> o_bcd=0x1234; o_busy high 16 cycles; o_bin_vld pulse at edge 16; o_bin=1234 (0x04D2); o_err=0.
- Digits 9,9,9,9 then enter -> o_bin=9999 (0x270F); then digit 7 -> o_bcd=0x0007, cnt=1 (committed restart).
- Enter with empty buffer -> o_bin=0, vld pulse after 16 cycles. Digit 0xA -> ignored, o_err=1, stays 1 until i_clear.
- Digits 1..5 -> o_bcd=0x1234, cnt=4, o_err=1; enter -> o_bin=1234.
- Enter, then i_clear at iteration 8 -> o_busy=0 next cycle; no o_bin_vld; o_bin keeps its previous value; o_bcd=0.
- Same-cycle i_enter+i_digit_vld (digit 5) with buffer 0x0012 -> digit dropped; o_bin=12. Assert reset mid-CONV -> all outputs 0 immediately.
